// File: rtl/cc_tag_comparator.sv
// Cache controller lookup stage: reads the tag/data SRAMs for each accepted
// read request, pushes a hit flag (and the line on a hit) toward the data
// reorder unit, and forwards misses to the miss handler.
// Optional feature macro: CC_HIT_UNDER_MISS_EN -- when defined the stage
// returns to IDLE right after the miss handshake instead of waiting for the
// line fill (miss_done_i is then unused).
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | ready for a request (subject to FIFO almost-full)
// ST_COMPARE   | SRAM data valid; compare tag, push flag (and line on hit)
// ST_MISS_REQ  | presenting the line address to the miss handler
// ST_MISS_WAIT | waiting for the line fill to complete (default build only)
module cc_tag_comparator #(
    parameter  int IDX_WIDTH = 9,
    localparam int TAG_WIDTH = 32 - 6 - IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inct_araddr_i,
    input  logic                 inct_arvalid_i,
    output logic                 inct_arready_o,
    output logic                 tag_sram_rden_o,
    output logic [IDX_WIDTH-1:0] tag_sram_raddr_o,
    input  logic [TAG_WIDTH:0]   tag_sram_rdata_i,
    output logic                 data_sram_rden_o,
    output logic [IDX_WIDTH-1:0] data_sram_raddr_o,
    input  logic [511:0]         data_sram_rdata_i,
    input  logic                 hit_flag_fifo_afull_i,
    output logic                 hit_flag_fifo_wren_o,
    output logic                 hit_flag_fifo_wdata_o,
    input  logic                 hit_data_fifo_afull_i,
    output logic                 hit_data_fifo_wren_o,
    output logic [517:0]         hit_data_fifo_wdata_o,
    output logic                 miss_req_valid_o,
    input  logic                 miss_req_ready_i,
    output logic [31:0]          miss_addr_o,
    input  logic                 miss_done_i
);

`ifdef CC_HIT_UNDER_MISS_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPARE  = 2'd1,
        ST_MISS_REQ = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_MISS_REQ  = 2'd2,
        ST_MISS_WAIT = 2'd3
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [25:0] req_line_q;     // araddr[31:6] of the request in flight
    logic [5:0]  req_off_q;
    logic        miss_valid_q;
    logic [31:0] miss_addr_q;

    logic        accept;
    logic        tag_hit;
    logic        in_compare;
    logic        miss_hs;

`ifdef CC_HIT_UNDER_MISS_EN
    logic        unused_miss_done;
    assign unused_miss_done = miss_done_i;
`endif

    // Tag compare against the registered request; SRAM output is valid in COMPARE.
    always_comb begin
        tag_hit    = tag_sram_rdata_i[TAG_WIDTH] &
                     (tag_sram_rdata_i[TAG_WIDTH-1:0] == req_line_q[25:IDX_WIDTH]);
        in_compare = (state_q == ST_COMPARE) && !rst;
        miss_hs    = miss_valid_q & miss_req_ready_i;
    end

    // Next-state and handshake/strobe outputs; afull is only looked at in IDLE.
    always_comb begin
        state_d               = state_q;
        inct_arready_o        = 1'b0;
        accept                = 1'b0;
        tag_sram_rden_o       = 1'b0;
        data_sram_rden_o      = 1'b0;
        tag_sram_raddr_o      = '0;
        data_sram_raddr_o     = '0;
        hit_flag_fifo_wren_o  = 1'b0;
        hit_flag_fifo_wdata_o = 1'b0;
        hit_data_fifo_wren_o  = 1'b0;
        hit_data_fifo_wdata_o = '0;

        inct_arready_o = (state_q == ST_IDLE) && !hit_flag_fifo_afull_i &&
                         !hit_data_fifo_afull_i && !rst;
        accept         = inct_arready_o & inct_arvalid_i;

        if (accept) begin
            tag_sram_rden_o   = 1'b1;
            data_sram_rden_o  = 1'b1;
            tag_sram_raddr_o  = inct_araddr_i[6 +: IDX_WIDTH];
            data_sram_raddr_o = inct_araddr_i[6 +: IDX_WIDTH];
        end

        if (in_compare) begin
            hit_flag_fifo_wren_o  = 1'b1;
            hit_flag_fifo_wdata_o = tag_hit;
            if (tag_hit) begin
                hit_data_fifo_wren_o  = 1'b1;
                hit_data_fifo_wdata_o = {req_off_q, data_sram_rdata_i};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                state_d = tag_hit ? ST_IDLE : ST_MISS_REQ;
            end
            ST_MISS_REQ: begin
`ifdef CC_HIT_UNDER_MISS_EN
                if (miss_hs) state_d = ST_IDLE;
`else
                if (miss_hs) state_d = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (miss_done_i) state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, request capture and registered miss interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_line_q   <= '0;
            req_off_q    <= '0;
            miss_valid_q <= 1'b0;
            miss_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            miss_valid_q <= (state_d == ST_MISS_REQ);
            if (accept) begin
                req_line_q <= inct_araddr_i[31:6];
                req_off_q  <= inct_araddr_i[5:0];
            end
            if ((state_q == ST_COMPARE) && !tag_hit) begin
                miss_addr_q <= {req_line_q, 6'b0};
            end
        end
    end

    assign miss_req_valid_o = miss_valid_q;
    assign miss_addr_o      = miss_addr_q;

endmodule

// File: tb/tb_cc_tag_comparator.sv
// Bench for cc_tag_comparator: SRAM behavioural model, directed scenarios,
// then randomized traffic with a scoreboard fed at acceptance and drained
// by a monitor watching the FIFO pushes and miss handshakes.
module tb_cc_tag_comparator;

    logic         clk;
    logic         rst;
    logic [31:0]  inct_araddr_i;
    logic         inct_arvalid_i;
    logic         inct_arready_o;
    logic         tag_sram_rden_o;
    logic [8:0]   tag_sram_raddr_o;
    logic [17:0]  tag_sram_rdata_i;
    logic         data_sram_rden_o;
    logic [8:0]   data_sram_raddr_o;
    logic [511:0] data_sram_rdata_i;
    logic         hit_flag_fifo_afull_i;
    logic         hit_flag_fifo_wren_o;
    logic         hit_flag_fifo_wdata_o;
    logic         hit_data_fifo_afull_i;
    logic         hit_data_fifo_wren_o;
    logic [517:0] hit_data_fifo_wdata_o;
    logic         miss_req_valid_o;
    logic         miss_req_ready_i;
    logic [31:0]  miss_addr_o;
    logic         miss_done_i;

    cc_tag_comparator dut (
        .clk                   (clk),
        .rst                   (rst),
        .inct_araddr_i         (inct_araddr_i),
        .inct_arvalid_i        (inct_arvalid_i),
        .inct_arready_o        (inct_arready_o),
        .tag_sram_rden_o       (tag_sram_rden_o),
        .tag_sram_raddr_o      (tag_sram_raddr_o),
        .tag_sram_rdata_i      (tag_sram_rdata_i),
        .data_sram_rden_o      (data_sram_rden_o),
        .data_sram_raddr_o     (data_sram_raddr_o),
        .data_sram_rdata_i     (data_sram_rdata_i),
        .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
        .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
        .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
        .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
        .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
        .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
        .miss_req_valid_o      (miss_req_valid_o),
        .miss_req_ready_i      (miss_req_ready_i),
        .miss_addr_o           (miss_addr_o),
        .miss_done_i           (miss_done_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [17:0]  tag_mem  [512];
    logic [511:0] data_mem [512];

    logic         exp_flag [$];
    logic [517:0] exp_data [$];
    logic [31:0]  exp_miss [$];

    int vectors = 0;
    int miscompares = 0;
    bit rand_done = 0;

    // Synchronous SRAMs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (tag_sram_rden_o)  tag_sram_rdata_i  <= tag_mem[tag_sram_raddr_o];
        if (data_sram_rden_o) data_sram_rdata_i <= data_mem[data_sram_raddr_o];
    end

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check518(input string name, input logic [517:0] act, input logic [517:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] mk_addr(input logic [16:0] tag, input logic [8:0] idx,
                                            input logic [5:0] off);
        return {tag, idx, off};
    endfunction

    // Reference model: direct-mapped lookup against the current memory contents.
    task automatic push_expect(input logic [31:0] addr);
        logic [17:0] e;
        logic        hit;
        e   = tag_mem[addr[14:6]];
        hit = e[17] && (e[16:0] == addr[31:15]);
        exp_flag.push_back(hit);
        if (hit) exp_data.push_back({addr[5:0], data_mem[addr[14:6]]});
        else     exp_miss.push_back({addr[31:6], 6'b0});
    endtask

    // Monitor: pop and compare whenever the DUT pushes or hands off a miss.
    always @(negedge clk) begin
        if (hit_flag_fifo_wren_o) begin
            if (exp_flag.size() == 0) begin
                check1("flag_unexpected_push", 1'b1, 1'b0);
            end else begin
                logic ef;
                ef = exp_flag.pop_front();
                check1("hit_flag", hit_flag_fifo_wdata_o, ef);
                check1("data_push_with_hit", hit_data_fifo_wren_o, ef);
            end
        end else if (hit_data_fifo_wren_o) begin
            check1("data_push_without_flag", 1'b1, 1'b0);
        end
        if (hit_data_fifo_wren_o) begin
            if (exp_data.size() == 0) check1("data_unexpected_push", 1'b1, 1'b0);
            else check518("hit_data", hit_data_fifo_wdata_o, exp_data.pop_front());
        end
        if (miss_req_valid_o && miss_req_ready_i) begin
            if (exp_miss.size() == 0) check1("miss_unexpected", 1'b1, 1'b0);
            else check32("miss_addr_hs", miss_addr_o, exp_miss.pop_front());
        end
    end

    task automatic do_req(input logic [31:0] addr, input int bound);
        int n;
        n = 0;
        inct_araddr_i  = addr;
        inct_arvalid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (inct_arready_o) begin
                push_expect(addr);
                break;
            end
            n++;
            if (n > bound) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: addr %h not accepted, expected within %0d cycles",
                         addr, bound);
                break;
            end
        end
        @(posedge clk); #1;
        inct_arvalid_i = 1'b0;
    endtask

    // Called at a negedge with arvalid already up.
    task automatic finish_accept(input logic [31:0] addr);
        if (inct_arready_o) begin
            push_expect(addr);
            @(posedge clk); #1;
            inct_arvalid_i = 1'b0;
        end else begin
            do_req(addr, 20);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [511:0] hit_line;
        int n;
        int done_cnt;

        rst = 1'b1;
        inct_araddr_i = '0;
        inct_arvalid_i = 1'b0;
        hit_flag_fifo_afull_i = 1'b0;
        hit_data_fifo_afull_i = 1'b0;
        miss_req_ready_i = 1'b0;
        miss_done_i = 1'b0;
        tag_sram_rdata_i = '0;
        data_sram_rdata_i = '0;
        for (int i = 0; i < 512; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = rand_line();
        end

        // Reset: arready forced low even with a pending request.
        @(posedge clk); #1;
        inct_araddr_i = 32'h0000_1248;
        inct_arvalid_i = 1'b1;
        @(negedge clk);
        check1("rst_arready", inct_arready_o, 1'b0);
        check1("rst_tag_rden", tag_sram_rden_o, 1'b0);
        check1("rst_flag_wren", hit_flag_fifo_wren_o, 1'b0);
        check1("rst_data_wren", hit_data_fifo_wren_o, 1'b0);
        check1("rst_miss_valid", miss_req_valid_o, 1'b0);
        check32("rst_miss_addr", miss_addr_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        inct_arvalid_i = 1'b0;
        @(negedge clk);
        check1("idle_arready", inct_arready_o, 1'b1);
        settle(1);

        // Hit at 0x1248.
        tag_mem[9'h049] = 18'h20000;
        hit_line = data_mem[9'h049];
        inct_araddr_i = 32'h0000_1248;
        inct_arvalid_i = 1'b1;
        @(negedge clk);
        check1("hit_tag_rden", tag_sram_rden_o, 1'b1);
        check1("hit_data_rden", data_sram_rden_o, 1'b1);
        check32("hit_tag_raddr", 32'(tag_sram_raddr_o), 32'h049);
        check32("hit_data_raddr", 32'(data_sram_raddr_o), 32'h049);
        finish_accept(32'h0000_1248);
        @(negedge clk);
        check1("hit_push_flag", hit_flag_fifo_wren_o, 1'b1);
        check518("hit_push_data", hit_data_fifo_wdata_o, {6'h08, hit_line});
        check1("hit_arready_busy", inct_arready_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check1("hit_arready_again", inct_arready_o, 1'b1);
        settle(1);

        // Miss at 0x1248 with a slow miss handler.
        tag_mem[9'h049] = 18'h00000;
        inct_araddr_i = 32'h0000_1248;
        inct_arvalid_i = 1'b1;
        @(negedge clk);
        finish_accept(32'h0000_1248);
        @(negedge clk);
        check1("miss_flag_push", hit_flag_fifo_wren_o, 1'b1);
        check1("miss_no_data_push", hit_data_fifo_wren_o, 1'b0);
        check1("miss_valid_not_yet", miss_req_valid_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check1("miss_valid_rise", miss_req_valid_o, 1'b1);
        check32("miss_addr", miss_addr_o, 32'h0000_1240);
        repeat (5) begin
            @(posedge clk); #1;
            @(negedge clk);
            check1("miss_valid_held", miss_req_valid_o, 1'b1);
            check32("miss_addr_stable", miss_addr_o, 32'h0000_1240);
        end
        @(posedge clk); #1;
        miss_req_ready_i = 1'b1;
        @(posedge clk); #1;
        miss_req_ready_i = 1'b0;
        tag_mem[9'h049] = 18'h20000;
        inct_araddr_i = 32'h0000_1248;
        inct_arvalid_i = 1'b1;
`ifdef CC_HIT_UNDER_MISS_EN
        @(negedge clk);
        check1("hum_accept_after_hs", inct_arready_o, 1'b1);
        finish_accept(32'h0000_1248);
`else
        repeat (3) begin
            @(negedge clk);
            check1("miss_wait_blocked", inct_arready_o, 1'b0);
            check1("miss_valid_dropped", miss_req_valid_o, 1'b0);
            @(posedge clk); #1;
        end
        miss_done_i = 1'b1;
        @(negedge clk);
        check1("miss_done_cycle_arready", inct_arready_o, 1'b0);
        @(posedge clk); #1;
        miss_done_i = 1'b0;
        @(negedge clk);
        check1("arready_after_done", inct_arready_o, 1'b1);
        finish_accept(32'h0000_1248);
`endif
        settle(3);

        // Almost-full data FIFO blocks acceptance and SRAM reads.
        tag_mem[9'h022] = {1'b1, 17'h3};
        a = mk_addr(17'h3, 9'h022, 6'h3f);
        hit_data_fifo_afull_i = 1'b1;
        inct_araddr_i = a;
        inct_arvalid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check1("afull_arready", inct_arready_o, 1'b0);
            check1("afull_no_read", tag_sram_rden_o, 1'b0);
            @(posedge clk); #1;
        end
        hit_data_fifo_afull_i = 1'b0;
        @(negedge clk);
        check1("afull_drop_arready", inct_arready_o, 1'b1);
        check1("afull_drop_read", tag_sram_rden_o, 1'b1);
        finish_accept(a);
        settle(3);

        // Reset while in MISS_REQ drops the pending miss.
        tag_mem[9'h010] = {1'b1, 17'h5};
        do_req(mk_addr(17'h3, 9'h010, 6'h01), 20);
        n = 0;
        while (!miss_req_valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check1("rstmiss_reached_miss_req", miss_req_valid_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check1("rstmiss_no_flag", hit_flag_fifo_wren_o, 1'b0);
        check1("rstmiss_no_data", hit_data_fifo_wren_o, 1'b0);
        check1("rstmiss_arready", inct_arready_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_miss.delete();
        @(negedge clk);
        check1("rstmiss_valid_low", miss_req_valid_o, 1'b0);
        check1("rstmiss_idle", inct_arready_o, 1'b1);
        settle(1);

        // Randomized traffic over a few sets and tags so hits and misses mix.
        for (int i = 0; i < 8; i++)
            tag_mem[i] = {1'($urandom_range(0, 1)), 17'($urandom_range(0, 3))};
        done_cnt = 0;
        fork
            begin
                for (int r = 0; r < 150; r++) begin
                    do_req(mk_addr(17'($urandom_range(0, 3)), 9'($urandom_range(0, 7)),
                                   6'($urandom_range(0, 63))), 60);
                    settle($urandom_range(0, 2));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    if (miss_req_valid_o && miss_req_ready_i) begin
                        tag_mem[miss_addr_o[14:6]]  = {1'b1, miss_addr_o[31:15]};
                        data_mem[miss_addr_o[14:6]] = rand_line();
                        done_cnt = $urandom_range(1, 4);
                    end
                    @(posedge clk); #1;
                    miss_done_i = 1'b0;
                    if (done_cnt > 0) begin
                        done_cnt--;
                        if (done_cnt == 0) miss_done_i = 1'b1;
                    end
                    miss_req_ready_i      = ($urandom_range(0, 2) != 0);
                    hit_flag_fifo_afull_i = ($urandom_range(0, 4) == 0);
                    hit_data_fifo_afull_i = ($urandom_range(0, 4) == 0);
                end
            end
        join

        // Drain any outstanding miss.
        hit_flag_fifo_afull_i = 1'b0;
        hit_data_fifo_afull_i = 1'b0;
        miss_done_i = 1'b0;
        miss_req_ready_i = 1'b1;
        settle(4);
        miss_req_ready_i = 1'b0;
        miss_done_i = 1'b1;
        settle(1);
        miss_done_i = 1'b0;
        settle(3);
        check32("flag_queue_drained", 32'(exp_flag.size()), 32'd0);
        check32("data_queue_drained", 32'(exp_data.size()), 32'd0);
        check32("miss_queue_drained", 32'(exp_miss.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
